crc: RTL and testbench
======================

Name: crc

Overview:
- Parameterised serial CRC generator: bitwise polynomial long division, one message bit per clock.
- Takes a `width`-bit message and a `poly_width`-bit generator polynomial (MSB included).
- Produces the (`poly_width`-1)-bit remainder of message·x^(`poly_width`-1) mod poly.
- Standalone compute block; each computation is started by a reset pulse.
- Non-reflected, init 0, no final XOR.

Parameters:
- `width`, 32: message length in bits.
- `poly_width`, 9: generator polynomial length in bits, including the implicit-1 MSB. The CRC is `poly_width`-1 bits.

Ports:
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high. Its release starts a new computation.
- `message`  in  `width`: data to protect, MSB first. Must be stable from reset release until the first clock edge after release.
- `poly`  in  `poly_width`: generator polynomial, `poly[poly_width-1]` = x^(`poly_width`-1) term. Same stability rule as `message`.
- `crc_value`  out  `poly_width`-1: registered remainder.

Behaviour:
- One clock domain. Reset is asynchronous assert, and deasserts with `clk`.
- On reset:
  - `state`=INIT(0), `i`=0, `temp`=0, `shift_poly`=0, `crc_value`=0.
- Internal regs (named `state`, `i`, `shift_poly`, `temp`; benches probe them hierarchically):
  - `temp`: `width`+`poly_width`-1 bits.
  - `shift_poly`: same width as `temp`.
  - `i`: counter, at least clog2(`width`+1) bits.
  - `state`: 2 bits.
- INIT (first edge with reset low):
  - `temp` <= {`message`, (`poly_width`-1) zeros}.
  - `shift_poly` <= `poly` << (`width`-1), i.e. poly aligned under `temp` MSB.
  - `i` <= 0; -> CALC.
- CALC, each edge:
  - If `temp`[`width`+`poly_width`-2-`i`]==1, then `temp` <= `temp` ^ `shift_poly`; else `temp` unchanged.
  - `shift_poly` <= `shift_poly` >> 1; `i` <= `i`+1.
  - When `i`==`width`-1 on this edge -> DONE (exactly `width` CALC cycles).
- DONE:
  - On the entry edge, `crc_value` <= `temp`[`poly_width`-2:0]. Then hold all registers until the next reset.
- Latency:
  - `crc_value` is valid `width`+2 rising edges after reset release: 34 for default parameters.
  - `crc_value` keeps 0 (post-reset) until DONE is entered.
- `message`/`poly` changes after INIT are ignored for the current computation.
- Reset mid-computation aborts immediately and returns to INIT on release.
- `poly` MSB of 0 is not supported; the output is whatever the algorithm above yields. No error flag.
- No handshake or valid output; the consumer waits for the fixed latency.

Decomposition:
- Shared package holds:
  - state encoding constants: INIT=2'd0, CALC=2'd1, DONE=2'd2;
  - default `width`/`poly_width`.
- Single module; no sub-module needed. The XOR/shift datapath is small and inline.

Test Plan:
1. Defaults, `poly`=9'b100000111, `message`=32'h8F9CDBF8, reset pulse, wait 100 cycles -> `crc_value`=8'b01111011 (0x7B).
2. Without restarting the simulation, `poly`=9'b111010101, `message`=32'h33C3D0CA, reset pulse, wait -> `crc_value`=8'b10010100 (0x94).
3. Latency/reset values:
   - during reset, `crc_value`=0 and `state`=0;
   - after release, `crc_value` stays 0 through the 33rd edge and becomes valid exactly on the 34th;
   - `i` counts 0..32 while in CALC.
4. `message`=0, any `poly` -> `crc_value`=0. `message`=32'h00000001, `poly`=9'h107 -> `crc_value`=8'h07.
5. Reset asserted mid-CALC (after ~10 cycles) with new inputs (case 2 data), released -> correct 0x94, no residue from the aborted run.
6. Change `message` during CALC of case 1 -> result still 0x7B. `crc_value` holds 0x7B for 50 cycles in DONE.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared encodings and default sizes for the serial CRC generator.
package crc_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } crc_state_e;

  localparam int unsigned DEF_WIDTH      = 32;
  localparam int unsigned DEF_POLY_WIDTH = 9;

endpackage

// File: rtl/crc.sv
// Serial CRC generator: bitwise long division of message*x^(poly_width-1) by poly,
// one message bit per clock, restarted by every reset pulse.
module crc
  import crc_pkg::*;
#(
  parameter int unsigned width      = DEF_WIDTH,
  parameter int unsigned poly_width = DEF_POLY_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [width-1:0]        message,
  input  logic [poly_width-1:0]   poly,
  output logic [poly_width-2:0]   crc_value
);

  localparam int unsigned TW = width + poly_width - 1;
  localparam int unsigned IW = $clog2(width + 1);
  localparam logic [IW-1:0] LAST_I = IW'(width - 1);
  localparam logic [TW-1:0] TOP_BIT = {1'b1, {(TW-1){1'b0}}};

  crc_state_e      state;
  logic [IW-1:0]   i;
  logic [TW-1:0]   temp;
  logic [TW-1:0]   shift_poly;
  logic            lead_bit;

  // Dividend bit currently sitting above the MSB of the shifted polynomial.
  assign lead_bit = |(temp & (TOP_BIT >> i));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= INIT;
      i          <= '0;
      temp       <= '0;
      shift_poly <= '0;
      crc_value  <= '0;
    end else begin
      case (state)
        INIT: begin
          temp       <= {message, {(poly_width-1){1'b0}}};
          shift_poly <= TW'(poly) << (width - 1);
          i          <= '0;
          state      <= CALC;
        end
        CALC: begin
          if (lead_bit) begin
            temp <= temp ^ shift_poly;
          end
          shift_poly <= shift_poly >> 1;
          i          <= i + 1'b1;
          if (i == LAST_I) begin
            state <= DONE;
          end
        end
        DONE: begin
          crc_value <= temp[poly_width-2:0];
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc.sv
// Directed bench for the serial CRC generator with hand-computed remainders.
module tb_crc;

  logic        clk;
  logic        reset;
  logic [31:0] message;
  logic [8:0]  poly;
  logic [7:0]  crc_value;

  int n_checks = 0;
  int n_fail   = 0;

  crc dut (
    .clk       (clk),
    .reset     (reset),
    .message   (message),
    .poly      (poly),
    .crc_value (crc_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Applies inputs, pulses reset, returns at the falling edge right after release.
  task automatic start(input logic [31:0] m, input logic [8:0] p);
    message = m;
    poly    = p;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    message = '0;
    poly    = '0;
    #1;
    check("rst_crc", 32'(crc_value), 32'h0);
    check("rst_state", 32'(dut.state), 32'd0);
    check("rst_i", 32'(dut.i), 32'd0);
    @(negedge clk);

    // Case 1 with edge-by-edge latency and counter checks
    start(32'h8F9CDBF8, 9'b100000111);
    for (int k = 1; k <= 33; k++) begin
      @(posedge clk);
      #1;
      check("lat_zero", 32'(crc_value), 32'h0);
      check("cnt_i", 32'(dut.i), 32'(k - 1));
    end
    check("state_done", 32'(dut.state), 32'd2);
    wait_edges(1);
    check("case1_lat34", 32'(crc_value), 32'h7B);
    wait_edges(66);
    check("case1_100", 32'(crc_value), 32'h7B);

    // Case 2 without restarting the simulation
    start(32'h33C3D0CA, 9'b111010101);
    wait_edges(33);
    check("case2_pre", 32'(crc_value), 32'h0);
    wait_edges(1);
    check("case2", 32'(crc_value), 32'h94);

    // Degenerate messages
    start(32'h00000000, 9'h107);
    wait_edges(34);
    check("zero_msg_107", 32'(crc_value), 32'h0);
    start(32'h00000000, 9'h1D5);
    wait_edges(34);
    check("zero_msg_1d5", 32'(crc_value), 32'h0);
    start(32'h00000001, 9'h107);
    wait_edges(34);
    check("one_msg", 32'(crc_value), 32'h07);

    // Abort mid-CALC and restart with case 2 data
    start(32'h8F9CDBF8, 9'b100000111);
    wait_edges(10);
    reset = 1'b1;
    #1;
    check("abort_crc", 32'(crc_value), 32'h0);
    check("abort_state", 32'(dut.state), 32'd0);
    check("abort_temp", 32'(dut.temp != '0), 32'd0);
    message = 32'h33C3D0CA;
    poly    = 9'b111010101;
    @(negedge clk);
    reset = 1'b0;
    wait_edges(34);
    check("abort_case2", 32'(crc_value), 32'h94);

    // Inputs change during CALC; the captured values must win
    start(32'h8F9CDBF8, 9'b100000111);
    wait_edges(5);
    message = 32'hFFFF0000;
    poly    = 9'h1D5;
    wait_edges(29);
    check("late_change", 32'(crc_value), 32'h7B);
    for (int k = 0; k < 5; k++) begin
      wait_edges(10);
      check("hold", 32'(crc_value), 32'h7B);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
